washing_machine_plant: RTL and testbench
========================================

# washing_machine_plant

Behavioural plant model sitting on the opposite side of the washing machine controller interface. It consumes the controller's actuator outputs (valves, motor, soap/water wash, door lock) and produces the sensor inputs the controller waits on (door_close, filled, drained, detergent_added, cycle_timeout, spin_timeout). It models the water level, the detergent dispenser, the wash and spin timers, and the door. This lets the controller run closed-loop in simulation and on FPGA without hand-driven stimulus.

## Interface
- FULL_LEVEL, 10: water level at which `filled` asserts; must be at most 2^LEVEL_W-1.
- LEVEL_W, 8: width of the water level register.
- DET_CYCLES, 3: clocks of `soap_wash` needed before `detergent_added` sets; must be at least 1.
- WASH_CYCLES, 16: agitation clocks before `cycle_timeout` asserts; must be at least 1.
- SPIN_CYCLES, 12: spin clocks before `spin_timeout` asserts; must be at least 1.
- CNT_W, 8: width of the detergent, wash and spin counters; must hold the largest *_CYCLES value.

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  asynchronous reset, active-low (0 = reset).
- door_shut_req  in  1  user closes the door (level or pulse).
- door_open_req  in  1  user opens the door.
- door_lock  in  1  from controller.
- fill_valve_on  in  1  from controller.
- drain_valve_on  in  1  from controller.
- motor_on  in  1  from controller.
- soap_wash  in  1  from controller.
- water_wash  in  1  from controller; informational only, does not affect this block.
- done  in  1  from controller.
- door_close  out  1  door shut status.
- filled  out  1  level == FULL_LEVEL.
- drained  out  1  level == 0.
- detergent_added  out  1  sticky dispenser status.
- cycle_timeout  out  1  wash timer expired.
- spin_timeout  out  1  spin timer expired.
- level  out  LEVEL_W  current water level.
- fault  out  1  sticky illegal-actuation flag.

## Operation
- State is held in registers: level, det_cnt, wash_cnt, spin_cnt, door_close, detergent_added, fault. filled, drained, cycle_timeout and spin_timeout are decoded combinationally from these registers.
- Level:
  - fill_valve_on=1 and drain_valve_on=0: level increments, saturating at FULL_LEVEL.
  - drain_valve_on=1 and fill_valve_on=0: level decrements, saturating at 0.
  - Both valves 0 or both 1: level holds.
- Detergent:
  - While soap_wash=1 and detergent_added=0, det_cnt increments.
  - On the edge where det_cnt would reach DET_CYCLES, detergent_added sets and det_cnt clears.
  - While soap_wash=0 and detergent_added=0, det_cnt holds.
  - detergent_added clears only when done=1 or on reset. If done=1 and soap_wash=1 in the same cycle, the clear wins.
- Wash timer:
  - wash_cnt increments, saturating at WASH_CYCLES, while motor_on=1 and drain_valve_on=0. Otherwise it clears to 0.
  - cycle_timeout = (wash_cnt == WASH_CYCLES).
- Spin timer:
  - spin_cnt increments, saturating at SPIN_CYCLES, while motor_on=1 and drain_valve_on=1. Otherwise it clears to 0.
  - spin_timeout = (spin_cnt == SPIN_CYCLES).
- Door:
  - door_shut_req=1 sets door_close.
  - door_open_req=1 clears door_close only when door_lock=0.
  - Both requests high in the same cycle: door_close holds.
- Fault sets on any edge where either condition holds:
  - motor_on=1 and door_close=0;
  - fill_valve_on=1 and drain_valve_on=1.
  - fault clears only on reset.
- The plant does not change behaviour on fault.

## Timing
- Reset (asynchronous, effective immediately):
  - level=0, all counters=0, door_close=0, detergent_added=0, fault=0.
  - Resulting outputs: drained=1, filled=0, cycle_timeout=0, spin_timeout=0.
- Latencies:
  - Fill from empty with fill_valve_on held: filled=1 after exactly FULL_LEVEL rising edges.
  - Drain from full with drain_valve_on held: drained=1 after exactly FULL_LEVEL rising edges.
  - detergent_added=1 after DET_CYCLES edges of soap_wash=1.
  - cycle_timeout=1 after WASH_CYCLES agitation edges; spin_timeout=1 after SPIN_CYCLES spin edges.
- Both timeouts stay high until their enabling condition drops. They fall in the cycle after that edge.
- door_close changes one edge after the request.
- Reset asserted mid-fill or mid-spin returns all state to reset values asynchronously. After reset deasserts, counting restarts from 0.

## Test plan
- Fill then drain:
  - Hold fill_valve_on for 10 clocks: filled=1 on edge 10 and level=10; a further fill edge keeps level=10.
  - Then hold drain_valve_on for 10 clocks: drained=1 on edge 10 and level=0.
- Detergent, default parameters:
  - soap_wash high for 3 clocks: detergent_added=1 on edge 3.
  - Then done=1 for one clock: detergent_added=0 on the next edge.
- Wash then spin:
  - motor_on=1, drain_valve_on=0 for 16 clocks: cycle_timeout=1.
  - Raise drain_valve_on: cycle_timeout=0 next cycle, and spin_timeout=1 after 12 edges.
  - Drop motor_on: spin_timeout=0.
- Door:
  - door_shut_req pulse: door_close=1.
  - door_open_req with door_lock=1: door_close stays 1.
  - door_open_req with door_lock=0: door_close=0.
  - Both requests together: door_close holds.
- Faults and reset:
  - motor_on=1 with door_close=0: fault=1, and it stays 1 after motor_on drops.
  - Assert reset mid-fill at level=5: level=0, drained=1, fault=0 immediately, without waiting for a clock edge.
- Closed loop: connect to the washing machine controller with door_shut_req and start pulsed. The controller must reach done=1 with no fault.

Source files
------------

// File: rtl/washing_machine_plant.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : washing_machine_plant                                           |
// | Purpose  : Behavioural plant for the washing machine controller. It takes  |
// |            the controller's actuator outputs and produces the sensor       |
// |            inputs the controller waits on. It models the water level, the  |
// |            detergent dispenser, the wash and spin timers, and the door.    |
// | Ports    : clock_i          system clock, rising edge                      |
// |            reset_i          asynchronous reset, active-low                 |
// |            door_shut_req_i  user closes the door                           |
// |            door_open_req_i  user opens the door (ignored while locked)     |
// |            door_lock_i, fill_valve_on_i, drain_valve_on_i, motor_on_i,     |
// |            soap_wash_i, water_wash_i, done_i   controller actuators        |
// |            door_close_o, filled_o, drained_o, detergent_added_o,           |
// |            cycle_timeout_o, spin_timeout_o     sensor outputs              |
// |            level_o          current water level                            |
// |            fault_o          sticky illegal-actuation flag                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module washing_machine_plant #(
   parameter int FULL_LEVEL  = 10,
   parameter int LEVEL_W     = 8,
   parameter int DET_CYCLES  = 3,
   parameter int WASH_CYCLES = 16,
   parameter int SPIN_CYCLES = 12,
   parameter int CNT_W       = 8
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic               door_shut_req_i,
   input  logic               door_open_req_i,
   input  logic               door_lock_i,
   input  logic               fill_valve_on_i,
   input  logic               drain_valve_on_i,
   input  logic               motor_on_i,
   input  logic               soap_wash_i,
   input  logic               water_wash_i,
   input  logic               done_i,
   output logic               door_close_o,
   output logic               filled_o,
   output logic               drained_o,
   output logic               detergent_added_o,
   output logic               cycle_timeout_o,
   output logic               spin_timeout_o,
   output logic [LEVEL_W-1:0] level_o,
   output logic               fault_o
);

   localparam logic [LEVEL_W-1:0] C_FULL     = LEVEL_W'(FULL_LEVEL);
   localparam logic [CNT_W-1:0]   C_DET_LAST = CNT_W'(DET_CYCLES - 1);
   localparam logic [CNT_W-1:0]   C_WASH     = CNT_W'(WASH_CYCLES);
   localparam logic [CNT_W-1:0]   C_SPIN     = CNT_W'(SPIN_CYCLES);

   logic [LEVEL_W-1:0] level_q, level_d;
   logic [CNT_W-1:0]   det_cnt_q, det_cnt_d;
   logic [CNT_W-1:0]   wash_cnt_q, wash_cnt_d;
   logic [CNT_W-1:0]   spin_cnt_q, spin_cnt_d;
   logic               door_close_q, door_close_d;
   logic               det_added_q, det_added_d;
   logic               fault_q, fault_d;

   // water_wash is informational only; it has no effect on the plant.
   logic unused_water_wash;
   assign unused_water_wash = water_wash_i;

   always_comb begin
      level_d      = level_q;
      det_cnt_d    = det_cnt_q;
      det_added_d  = det_added_q;
      wash_cnt_d   = '0;
      spin_cnt_d   = '0;
      door_close_d = door_close_q;
      fault_d      = fault_q;

      // Level: exactly one valve open moves the level; both or neither holds it.
      if (fill_valve_on_i && !drain_valve_on_i) begin
         if (level_q != C_FULL) level_d = level_q + 1'b1;
      end else if (drain_valve_on_i && !fill_valve_on_i) begin
         if (level_q != '0) level_d = level_q - 1'b1;
      end

      // Detergent: done clears and overrides soap_wash in the same cycle.
      if (done_i) begin
         det_added_d = 1'b0;
         det_cnt_d   = '0;
      end else if (soap_wash_i && !det_added_q) begin
         if (det_cnt_q == C_DET_LAST) begin
            det_added_d = 1'b1;
            det_cnt_d   = '0;
         end else begin
            det_cnt_d = det_cnt_q + 1'b1;
         end
      end

      // Agitation and spin share the motor; the drain valve selects which runs.
      if (motor_on_i && !drain_valve_on_i)
         wash_cnt_d = (wash_cnt_q == C_WASH) ? wash_cnt_q : wash_cnt_q + 1'b1;
      if (motor_on_i && drain_valve_on_i)
         spin_cnt_d = (spin_cnt_q == C_SPIN) ? spin_cnt_q : spin_cnt_q + 1'b1;

      // Door: simultaneous requests leave the door as it is.
      if (door_shut_req_i && !door_open_req_i)
         door_close_d = 1'b1;
      else if (door_open_req_i && !door_shut_req_i && !door_lock_i)
         door_close_d = 1'b0;

      // Fault judges the door state as it was before this edge.
      if ((motor_on_i && !door_close_q) || (fill_valve_on_i && drain_valve_on_i))
         fault_d = 1'b1;
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         level_q      <= '0;
         det_cnt_q    <= '0;
         wash_cnt_q   <= '0;
         spin_cnt_q   <= '0;
         door_close_q <= 1'b0;
         det_added_q  <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         level_q      <= level_d;
         det_cnt_q    <= det_cnt_d;
         wash_cnt_q   <= wash_cnt_d;
         spin_cnt_q   <= spin_cnt_d;
         door_close_q <= door_close_d;
         det_added_q  <= det_added_d;
         fault_q      <= fault_d;
      end
   end

   assign level_o           = level_q;
   assign filled_o          = (level_q == C_FULL);
   assign drained_o         = (level_q == '0);
   assign detergent_added_o = det_added_q;
   assign cycle_timeout_o   = (wash_cnt_q == C_WASH);
   assign spin_timeout_o    = (spin_cnt_q == C_SPIN);
   assign door_close_o      = door_close_q;
   assign fault_o           = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_washing_machine_plant.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_washing_machine_plant                                        |
// | Purpose  : Self-checking bench for washing_machine_plant: a vector table,  |
// |            hand-written multi-cycle sequences and a randomized run scored  |
// |            against a behavioural model.                                    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_washing_machine_plant;

   localparam int FULL = 10;
   localparam int DETC = 3;
   localparam int WASH = 16;
   localparam int SPIN = 12;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       shut = 1'b0, open_r = 1'b0, lock = 1'b0;
   logic       fill = 1'b0, drain = 1'b0, motor = 1'b0, soap = 1'b0;
   logic       wwash = 1'b0, done = 1'b0;
   logic       door_close, filled, drained, det_added, cyc_to, spin_to, fault;
   logic [7:0] level;

   int n_asserts = 0;
   int n_fail    = 0;

   always #5 clock = ~clock;

   washing_machine_plant #(
      .FULL_LEVEL(FULL), .LEVEL_W(8), .DET_CYCLES(DETC),
      .WASH_CYCLES(WASH), .SPIN_CYCLES(SPIN), .CNT_W(8)
   ) dut (
      .clock_i(clock), .reset_i(reset),
      .door_shut_req_i(shut), .door_open_req_i(open_r), .door_lock_i(lock),
      .fill_valve_on_i(fill), .drain_valve_on_i(drain), .motor_on_i(motor),
      .soap_wash_i(soap), .water_wash_i(wwash), .done_i(done),
      .door_close_o(door_close), .filled_o(filled), .drained_o(drained),
      .detergent_added_o(det_added), .cycle_timeout_o(cyc_to),
      .spin_timeout_o(spin_to), .level_o(level), .fault_o(fault)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_asserts++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_in(input bit f, input bit d, input bit m, input bit s,
                         input bit dn, input bit sh, input bit op, input bit lk);
      fill = f; drain = d; motor = m; soap = s;
      done = dn; shut = sh; open_r = op; lock = lk;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      #2 reset = 1'b0;
      #1;
      chk("rst_level", int'(level), 0);
      chk("rst_drained", int'(drained), 1);
      chk("rst_filled", int'(filled), 0);
      chk("rst_cyc_to", int'(cyc_to), 0);
      chk("rst_spin_to", int'(spin_to), 0);
      chk("rst_det", int'(det_added), 0);
      chk("rst_close", int'(door_close), 0);
      chk("rst_fault", int'(fault), 0);
      @(negedge clock);
      reset = 1'b1;
   endtask

   // ------------------------------------------------------------------ table
   typedef struct {
      bit f, d, m, s, dn, sh, op, lk;
      int lvl;
      bit det, close, flt;
   } vec_t;

   vec_t tbl[16];

   function automatic vec_t mk(input bit f, input bit d, input bit m, input bit s,
                               input bit dn, input bit sh, input bit op, input bit lk,
                               input int lvl, input bit det, input bit close, input bit flt);
      vec_t v;
      v.f = f; v.d = d; v.m = m; v.s = s; v.dn = dn; v.sh = sh; v.op = op; v.lk = lk;
      v.lvl = lvl; v.det = det; v.close = close; v.flt = flt;
      return v;
   endfunction

   // ------------------------------------------------------------------ model
   // Tracks run lengths and totals rather than saturated counters.
   int m_level, m_soap_total, m_wash_run, m_spin_run;
   bit m_close, m_fault;

   task automatic model_reset();
      m_level = 0; m_soap_total = 0; m_wash_run = 0; m_spin_run = 0;
      m_close = 0; m_fault = 0;
   endtask

   task automatic model_step();
      if ((motor && !m_close) || (fill && drain)) m_fault = 1;
      if (fill && !drain)      m_level = (m_level + 1 > FULL) ? FULL : m_level + 1;
      else if (drain && !fill) m_level = (m_level - 1 < 0) ? 0 : m_level - 1;
      if (done)      m_soap_total = 0;
      else if (soap) m_soap_total++;
      m_wash_run = (motor && !drain) ? m_wash_run + 1 : 0;
      m_spin_run = (motor && drain)  ? m_spin_run + 1 : 0;
      if (shut && !open_r)               m_close = 1;
      else if (open_r && !shut && !lock) m_close = 0;
   endtask

   task automatic model_check();
      chk("rnd_level", int'(level), m_level);
      chk("rnd_filled", int'(filled), int'(m_level == FULL));
      chk("rnd_drained", int'(drained), int'(m_level == 0));
      chk("rnd_det", int'(det_added), int'(m_soap_total >= DETC));
      chk("rnd_cyc_to", int'(cyc_to), int'(m_wash_run >= WASH));
      chk("rnd_spin_to", int'(spin_to), int'(m_spin_run >= SPIN));
      chk("rnd_close", int'(door_close), int'(m_close));
      chk("rnd_fault", int'(fault), int'(m_fault));
   endtask

   initial begin
      //            f  d  m  s  dn sh op lk  lvl det cl flt
      tbl[0]  = mk(0, 0, 0, 0, 0, 1, 0, 0,  0,  0, 1, 0);
      tbl[1]  = mk(0, 0, 0, 0, 0, 0, 1, 1,  0,  0, 1, 0);
      tbl[2]  = mk(0, 0, 0, 0, 0, 1, 1, 0,  0,  0, 1, 0);
      tbl[3]  = mk(0, 0, 0, 0, 0, 0, 1, 0,  0,  0, 0, 0);
      tbl[4]  = mk(0, 0, 0, 0, 0, 1, 0, 0,  0,  0, 1, 0);
      tbl[5]  = mk(0, 0, 0, 1, 0, 0, 0, 0,  0,  0, 1, 0);
      tbl[6]  = mk(0, 0, 0, 1, 0, 0, 0, 0,  0,  0, 1, 0);
      tbl[7]  = mk(0, 0, 0, 1, 0, 0, 0, 0,  0,  1, 1, 0);
      tbl[8]  = mk(0, 0, 0, 1, 0, 0, 0, 0,  0,  1, 1, 0);
      tbl[9]  = mk(0, 0, 0, 1, 1, 0, 0, 0,  0,  0, 1, 0);
      tbl[10] = mk(1, 0, 0, 0, 0, 0, 0, 0,  1,  0, 1, 0);
      tbl[11] = mk(1, 0, 0, 0, 0, 0, 0, 0,  2,  0, 1, 0);
      tbl[12] = mk(0, 1, 0, 0, 0, 0, 0, 0,  1,  0, 1, 0);
      tbl[13] = mk(1, 1, 0, 0, 0, 0, 0, 0,  1,  0, 1, 1);
      tbl[14] = mk(0, 1, 0, 0, 0, 0, 0, 0,  0,  0, 1, 1);
      tbl[15] = mk(0, 1, 0, 0, 0, 0, 0, 0,  0,  0, 1, 1);

      do_reset();
      for (int i = 0; i < 16; i++) begin
         set_in(tbl[i].f, tbl[i].d, tbl[i].m, tbl[i].s,
                tbl[i].dn, tbl[i].sh, tbl[i].op, tbl[i].lk);
         tick();
         chk($sformatf("tbl%0d_level", i), int'(level), tbl[i].lvl);
         chk($sformatf("tbl%0d_drained", i), int'(drained), int'(tbl[i].lvl == 0));
         chk($sformatf("tbl%0d_det", i), int'(det_added), int'(tbl[i].det));
         chk($sformatf("tbl%0d_close", i), int'(door_close), int'(tbl[i].close));
         chk($sformatf("tbl%0d_fault", i), int'(fault), int'(tbl[i].flt));
      end

      // Fill and drain latency, with saturation at both ends.
      do_reset();
      set_in(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 1; i < FULL; i++) tick();
      chk("fill_edge9_filled", int'(filled), 0);
      chk("fill_edge9_level", int'(level), FULL - 1);
      tick();
      chk("fill_edge10_filled", int'(filled), 1);
      chk("fill_edge10_level", int'(level), FULL);
      tick();
      chk("fill_sat_level", int'(level), FULL);
      set_in(0, 1, 0, 0, 0, 0, 0, 0);
      for (int i = 1; i < FULL; i++) tick();
      chk("drain_edge9_drained", int'(drained), 0);
      tick();
      chk("drain_edge10_drained", int'(drained), 1);
      chk("drain_edge10_level", int'(level), 0);
      tick();
      chk("drain_sat_level", int'(level), 0);

      // Wash then spin.
      do_reset();
      set_in(0, 0, 0, 0, 0, 1, 0, 1);
      tick();
      set_in(0, 0, 1, 0, 0, 0, 0, 1);
      for (int i = 1; i < WASH; i++) tick();
      chk("wash_edge15_to", int'(cyc_to), 0);
      tick();
      chk("wash_edge16_to", int'(cyc_to), 1);
      tick();
      chk("wash_hold_to", int'(cyc_to), 1);
      drain = 1'b1;
      tick();
      chk("wash_drop_to", int'(cyc_to), 0);
      for (int i = 2; i < SPIN; i++) tick();
      chk("spin_edge11_to", int'(spin_to), 0);
      tick();
      chk("spin_edge12_to", int'(spin_to), 1);
      motor = 1'b0;
      tick();
      chk("spin_drop_to", int'(spin_to), 0);
      chk("spin_no_fault", int'(fault), 0);

      // Motor with the door open, then asynchronous reset mid-fill.
      do_reset();
      set_in(0, 0, 1, 0, 0, 0, 0, 0);
      tick();
      chk("motor_open_fault", int'(fault), 1);
      motor = 1'b0;
      tick();
      chk("fault_sticky", int'(fault), 1);
      fill = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("midfill_level", int'(level), 5);
      #2 reset = 1'b0;
      #1;
      chk("async_rst_level", int'(level), 0);
      chk("async_rst_drained", int'(drained), 1);
      chk("async_rst_fault", int'(fault), 0);
      fill = 1'b0;
      @(negedge clock);
      reset = 1'b1;

      // Randomized run against the model.
      for (int blk = 0; blk < 4; blk++) begin
         do_reset();
         model_reset();
         for (int c = 0; c < 500; c++) begin
            fill   = ($urandom_range(0, 2) == 0);
            drain  = ($urandom_range(0, 2) == 0);
            motor  = ($urandom_range(0, 1) == 0);
            soap   = ($urandom_range(0, 2) == 0);
            done   = ($urandom_range(0, 15) == 0);
            shut   = ($urandom_range(0, 5) == 0);
            open_r = ($urandom_range(0, 15) == 0);
            lock   = ($urandom_range(0, 1) == 0);
            wwash  = ($urandom_range(0, 1) == 0);
            @(posedge clock);
            model_step();
            #1;
            model_check();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
